// File: rtl/de2i_150_jtag_dbg_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | de2i_150_jtag_dbg_pkg : shared JTAG debug command types and IR codes   |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
package de2i_150_jtag_dbg_pkg;

  localparam int JTAG_IR_W = 2;
  localparam int JTAG_DR_W = 38;
  localparam int JTAG_NCH  = 2 ** JTAG_IR_W;

  localparam logic [JTAG_IR_W-1:0] IR_OCIMEM    = 2'd0;
  localparam logic [JTAG_IR_W-1:0] IR_TRACEMEM  = 2'd1;
  localparam logic [JTAG_IR_W-1:0] IR_BREAK     = 2'd2;
  localparam logic [JTAG_IR_W-1:0] IR_TRACECTRL = 2'd3;

  typedef struct packed {
    logic [JTAG_IR_W-1:0] ir;
    logic [JTAG_DR_W-1:0] dr;
  } jtag_cmd_t;

  function automatic logic [JTAG_NCH-1:0] onehot(input logic [JTAG_IR_W-1:0] ir);
    onehot = JTAG_NCH'(1) << ir;
  endfunction

endpackage
`default_nettype wire

// File: rtl/de2i_150_jtag_cmd_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | de2i_150_jtag_cmd_fifo : first-word fall-through command FIFO          |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module de2i_150_jtag_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 40,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [LW-1:0] count;
  logic          do_pop;
  logic          do_push;

  assign full    = (count == LW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];
  assign level   = count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/de2i_150_nios2_jtag_cmd_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | de2i_150_nios2_jtag_cmd_sequencer : sysclk JTAG command queue + issue  |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module de2i_150_nios2_jtag_cmd_sequencer
  import de2i_150_jtag_dbg_pkg::*;
#(
  parameter int IR_W        = JTAG_IR_W,
  parameter int DR_W        = JTAG_DR_W,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ACTION_BIT  = 35
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         vs_udr,
  input  logic                         vs_uir,
  input  logic [IR_W-1:0]              ir_in,
  input  logic [DR_W-1:0]              sr,
  input  logic                         cmd_ready,
  output logic                         cmd_valid,
  output logic [IR_W-1:0]              cmd_ir,
  output logic [DR_W-1:0]              cmd_jdo,
  output logic [2**IR_W-1:0]           take_action,
  output logic [2**IR_W-1:0]           take_no_action,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
  output logic                         overflow
);

  localparam int NCH = 2 ** IR_W;
  localparam int LW  = $clog2(DEPTH + 1);
  localparam int CW  = IR_W + DR_W;

  logic [SYNC_STAGES-1:0] udr_sync, uir_sync, fill;
  logic                   sync_ok;
  logic                   udr_s, uir_s, udr_prev, uir_prev;
  logic                   udr_armed, uir_armed;
  logic                   udr_p, uir_p;
  logic                   pop, full, empty;
  logic [NCH-1:0]         ch;

  // fill marks when the sync chains hold real samples rather than reset zeros,
  // so a strobe already high at reset release never looks like a rising edge.
  assign sync_ok = fill[SYNC_STAGES-1];
  assign udr_s   = udr_sync[SYNC_STAGES-1];
  assign uir_s   = uir_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      udr_sync  <= '0;
      uir_sync  <= '0;
      fill      <= '0;
      udr_prev  <= 1'b0;
      uir_prev  <= 1'b0;
      udr_armed <= 1'b0;
      uir_armed <= 1'b0;
      udr_p     <= 1'b0;
      uir_p     <= 1'b0;
    end else begin
      udr_sync  <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
      uir_sync  <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
      fill      <= {fill[SYNC_STAGES-2:0], 1'b1};
      udr_prev  <= udr_s;
      uir_prev  <= uir_s;
      udr_armed <= udr_armed || (sync_ok && !udr_s);
      uir_armed <= uir_armed || (sync_ok && !uir_s);
      udr_p     <= udr_armed && udr_s && !udr_prev;
      uir_p     <= uir_armed && uir_s && !uir_prev;
    end
  end

  assign cmd_valid = !empty;
  assign pop       = cmd_valid && cmd_ready;

  de2i_150_jtag_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (CW),
    .LW    (LW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (udr_p),
    .push_data ({ir_in, sr}),
    .pop       (pop),
    .head      ({cmd_ir, cmd_jdo}),
    .full      (full),
    .empty     (empty),
    .level     (fifo_level)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (udr_p && full && !pop) begin
      overflow <= 1'b1;
    end else if (uir_p) begin
      overflow <= 1'b0;
    end
  end

  generate
    if (IR_W == JTAG_IR_W) begin : g_pkg_onehot
      assign ch = onehot(cmd_ir);
    end else begin : g_shift_onehot
      assign ch = NCH'(1) << cmd_ir;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      take_action    <= '0;
      take_no_action <= '0;
    end else begin
      take_action    <= (pop &&  cmd_jdo[ACTION_BIT]) ? ch : '0;
      take_no_action <= (pop && !cmd_jdo[ACTION_BIT]) ? ch : '0;
    end
  end

endmodule
`default_nettype wire
